// File: rtl/marble_bit_column.sv
// Clocked column of WIDTH marble BIT cells forming a ripple binary counter.
// A marble toggles one BIT per clock and carries down while it finds 1s.
module marble_bit_column #(
  parameter int unsigned      WIDTH  = 4,
  parameter logic [WIDTH-1:0] INIT   = '0,
  parameter bit               GEARED = 1'b0,
  localparam int unsigned     PW     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_left,
  input  logic             i_right,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  output logic             o_ready,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_value,
  output logic             o_right,
  output logic             o_left,
  output logic [PW-1:0]    o_exit_stage,
  output logic             o_drop
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  localparam logic [WIDTH-1:0] RST_VALUE = GEARED ? {WIDTH{INIT[0]}} : INIT;
  localparam logic [PW-1:0]    LAST      = PW'(WIDTH - 1);

  state_t           state;
  logic [PW-1:0]    ptr;
  logic             arrive;
  logic             cur_bit;
  logic [WIDTH-1:0] load_next;
  logic [WIDTH-1:0] toggle_mask;

  always_comb begin
    arrive      = i_left | i_right;
    load_next   = GEARED ? {WIDTH{i_load_value[0]}} : i_load_value;
    // Geared columns turn every BIT at once; the exit side follows BIT 0.
    toggle_mask = GEARED ? '1 : (WIDTH'(1) << ptr);
    cur_bit     = GEARED ? o_value[0] : o_value[ptr];
  end

  always_comb begin
    o_ready = (state == S_IDLE);
    o_busy  = (state == S_RUN);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      ptr          <= '0;
      o_value      <= RST_VALUE;
      o_right      <= 1'b0;
      o_left       <= 1'b0;
      o_exit_stage <= '0;
      o_drop       <= 1'b0;
    end else begin
      o_right <= 1'b0;
      o_left  <= 1'b0;
      o_drop  <= 1'b0;
      if (i_load) begin
        o_value <= load_next;
        state   <= S_IDLE;
        ptr     <= '0;
        o_drop  <= arrive;
      end else begin
        case (state)
          S_IDLE: begin
            ptr <= '0;
            // Two simultaneous marbles: one enters, the other falls off.
            o_drop <= i_left & i_right;
            if (arrive) begin
              state <= S_RUN;
            end
          end
          S_RUN: begin
            o_drop  <= arrive;
            o_value <= o_value ^ toggle_mask;
            if (!cur_bit) begin
              o_right      <= 1'b1;
              o_exit_stage <= ptr;
              state        <= S_IDLE;
              ptr          <= '0;
            end else if (GEARED || ptr == LAST) begin
              o_left       <= 1'b1;
              o_exit_stage <= ptr;
              state        <= S_IDLE;
              ptr          <= '0;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            ptr   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_marble_bit_column.sv
// Bench for marble_bit_column: a plain and a geared column share one stimulus
// stream; an arithmetic reference model feeds a scoreboard read by a monitor.
module tb_marble_bit_column;

  typedef struct {
    bit         left;
    int         stage;
    logic [3:0] val;
    int         stamp;
  } exit_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_left = 1'b0;
  logic i_right = 1'b0;
  logic i_load = 1'b0;
  logic [3:0] i_load_value = '0;

  logic [1:0]      rdy, bsy, rgt, lft, drp;
  logic [1:0][3:0] value;
  logic [1:0][1:0] stage;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;

  logic [3:0] initv [2];
  logic [3:0] mval [2];
  int         rem [2];
  exit_t      pend [2];
  exit_t      xq0 [$];
  exit_t      xq1 [$];
  int         dq0 [$];
  int         dq1 [$];

  logic [3:0] traj [5] = '{4'b0111, 4'b0110, 4'b0100, 4'b0000, 4'b1000};
  int unsigned p;

  marble_bit_column #(.WIDTH(4), .INIT(4'b0111), .GEARED(1'b0)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_left(i_left), .i_right(i_right),
    .i_load(i_load), .i_load_value(i_load_value),
    .o_ready(rdy[0]), .o_busy(bsy[0]), .o_value(value[0]), .o_right(rgt[0]),
    .o_left(lft[0]), .o_exit_stage(stage[0]), .o_drop(drp[0])
  );

  marble_bit_column #(.WIDTH(4), .INIT(4'b0000), .GEARED(1'b1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_left(i_left), .i_right(i_right),
    .i_load(i_load), .i_load_value(i_load_value),
    .o_ready(rdy[1]), .o_busy(bsy[1]), .o_value(value[1]), .o_right(rgt[1]),
    .o_left(lft[1]), .o_exit_stage(stage[1]), .o_drop(drp[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic int exit_size(int d);
    return (d == 0) ? xq0.size() : xq1.size();
  endfunction

  function automatic int exit_head_stamp(int d);
    return (d == 0) ? xq0[0].stamp : xq1[0].stamp;
  endfunction

  function automatic exit_t exit_pop(int d);
    if (d == 0) return xq0.pop_front();
    return xq1.pop_front();
  endfunction

  function automatic int drop_size(int d);
    return (d == 0) ? dq0.size() : dq1.size();
  endfunction

  function automatic int drop_pop(int d);
    if (d == 0) return dq0.pop_front();
    return dq1.pop_front();
  endfunction

  task automatic push_exit(int d, exit_t e);
    if (d == 0) xq0.push_back(e);
    else xq1.push_back(e);
  endtask

  task automatic push_drop(int d, int stamp);
    if (d == 0) dq0.push_back(stamp);
    else dq1.push_back(stamp);
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Reference model: whole-marble effect as counter arithmetic, plus a busy timer.
  task automatic apply(int d, bit l, bit r, bit ld, logic [3:0] ldv);
    logic [3:0] nxt;
    logic [4:0] chg;
    bit drop;
    drop = 1'b0;
    if (ld) begin
      mval[d] = (d == 1) ? {4{ldv[0]}} : ldv;
      rem[d]  = 0;
      drop    = l | r;
    end else if (rem[d] > 0) begin
      drop = l | r;
      rem[d]--;
      if (rem[d] == 0) begin
        pend[d].stamp = cyc_cnt + 1;
        push_exit(d, pend[d]);
      end
    end else if (l | r) begin
      if (d == 1) begin
        nxt           = ~mval[d];
        pend[d].left  = mval[d][0];
        pend[d].stage = 0;
      end else begin
        nxt           = mval[d] + 4'd1;
        chg           = {1'b0, mval[d] ^ nxt} + 5'd1;
        pend[d].left  = (nxt == 4'd0);
        pend[d].stage = $clog2(chg) - 1;
      end
      pend[d].val = nxt;
      mval[d]     = nxt;
      rem[d]      = pend[d].stage + 1;
      drop        = l & r;
    end
    if (drop) push_drop(d, cyc_cnt + 1);
  endtask

  task automatic cyc(bit l, bit r, bit ld, logic [3:0] ldv);
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d_ready", d), 32'(rdy[d]), 32'(rem[d] == 0));
      chk($sformatf("dut%0d_busy", d), 32'(bsy[d]), 32'(rem[d] > 0));
      if (rem[d] == 0) chk($sformatf("dut%0d_value", d), 32'(value[d]), 32'(mval[d]));
    end
    for (int d = 0; d < 2; d++) apply(d, l, r, ld, ldv);
    i_left       = l;
    i_right      = r;
    i_load       = ld;
    i_load_value = ldv;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    i_left  = 1'b0;
    i_right = 1'b0;
    i_load  = 1'b0;
    rst_n   = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d_rst_value", d), 32'(value[d]), 32'(initv[d]));
      chk($sformatf("dut%0d_rst_ready", d), 32'(rdy[d]), 32'd1);
      chk($sformatf("dut%0d_rst_busy", d), 32'(bsy[d]), 32'd0);
      chk($sformatf("dut%0d_rst_pulses", d), 32'({rgt[d], lft[d], drp[d]}), 32'd0);
      chk($sformatf("dut%0d_rst_stage", d), 32'(stage[d]), 32'd0);
      mval[d] = initv[d];
      rem[d]  = 0;
    end
    xq0.delete();
    xq1.delete();
    dq0.delete();
    dq1.delete();
    #1 rst_n = 1'b1;
  endtask

  task automatic mon_exit(int d);
    exit_t e;
    if (rgt[d] || lft[d]) begin
      checks++;
      if (exit_size(d) == 0) begin
        failures++;
        $display("FAIL dut%0d unexpected_exit: got right=%0b left=%0b stage=%0d at cycle %0d, required no exit",
                 d, rgt[d], lft[d], stage[d], cyc_cnt);
      end else begin
        e = exit_pop(d);
        if (rgt[d] !== !e.left || lft[d] !== e.left || int'(stage[d]) != e.stage ||
            value[d] !== e.val || cyc_cnt != e.stamp) begin
          failures++;
          $display("FAIL dut%0d exit: got right=%0b left=%0b stage=%0d value=%b cycle=%0d, required right=%0b left=%0b stage=%0d value=%b cycle=%0d",
                   d, rgt[d], lft[d], stage[d], value[d], cyc_cnt, !e.left, e.left, e.stage, e.val, e.stamp);
        end
      end
    end else if (exit_size(d) != 0 && exit_head_stamp(d) <= cyc_cnt) begin
      checks++;
      failures++;
      e = exit_pop(d);
      $display("FAIL dut%0d missing_exit: got no exit at cycle %0d, required left=%0b stage=%0d",
               d, cyc_cnt, e.left, e.stage);
    end
  endtask

  task automatic mon_drop(int d);
    int s;
    if (drp[d]) begin
      checks++;
      if (drop_size(d) == 0) begin
        failures++;
        $display("FAIL dut%0d unexpected_drop: got drop at cycle %0d, required none", d, cyc_cnt);
      end else begin
        s = drop_pop(d);
        if (s != cyc_cnt) begin
          failures++;
          $display("FAIL dut%0d drop_time: got cycle %0d required cycle %0d", d, cyc_cnt, s);
        end
      end
    end else if (drop_size(d) != 0 && dq_head(d) <= cyc_cnt) begin
      checks++;
      failures++;
      s = drop_pop(d);
      $display("FAIL dut%0d missing_drop: got none at cycle %0d required drop at cycle %0d", d, cyc_cnt, s);
    end
  endtask

  function automatic int dq_head(int d);
    return (d == 0) ? dq0[0] : dq1[0];
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      mon_exit(d);
      mon_drop(d);
    end
  end

  initial begin
    initv[0] = 4'b0111;
    initv[1] = 4'b0000;
    do_reset();

    // single marble from zero
    cyc(1'b0, 1'b0, 1'b1, 4'b0000);
    cyc(1'b0, 1'b1, 1'b0, 4'h0);
    idle(1);
    chk("zero_accept_value", 32'(value[0]), 32'h0);
    idle(1);
    chk("zero_after_toggle", 32'(value[0]), 32'h1);
    idle(3);

    // carry chain with visible intermediate states
    cyc(1'b0, 1'b0, 1'b1, 4'b0111);
    cyc(1'b1, 1'b0, 1'b0, 4'h0);
    for (int k = 0; k < 5; k++) begin
      idle(1);
      chk($sformatf("carry_traj%0d", k), 32'(value[0]), 32'(traj[k]));
    end
    idle(2);

    // overflow
    cyc(1'b0, 1'b0, 1'b1, 4'b1111);
    cyc(1'b0, 1'b1, 1'b0, 4'h0);
    idle(6);
    chk("overflow_value", 32'(value[0]), 32'h0);

    // second marble while busy, then two marbles at once
    cyc(1'b0, 1'b0, 1'b1, 4'b0011);
    cyc(1'b1, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 1'b1, 1'b0, 4'h0);
    idle(5);
    chk("busy_drop_value", 32'(value[0]), 32'b0100);
    cyc(1'b1, 1'b1, 1'b0, 4'h0);
    idle(5);

    // load aborts a carrying marble
    cyc(1'b0, 1'b0, 1'b1, 4'b0111);
    cyc(1'b1, 1'b0, 1'b0, 4'h0);
    idle(1);
    cyc(1'b0, 1'b0, 1'b1, 4'b1010);
    idle(1);
    chk("load_abort_value", 32'(value[0]), 32'b1010);
    chk("load_abort_ready", 32'(rdy[0]), 32'd1);
    idle(3);

    // reset aborts a carrying marble
    cyc(1'b0, 1'b0, 1'b1, 4'b0111);
    cyc(1'b1, 1'b0, 1'b0, 4'h0);
    idle(1);
    do_reset();
    idle(3);

    // geared column: three marbles three cycles apart
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 4'h0);
      idle(2);
      chk($sformatf("geared_value%0d", k), 32'(value[1]), (k == 1) ? 32'h0 : 32'hF);
    end
    idle(3);

    for (int n = 0; n < 1500; n++) begin
      p = $urandom_range(0, 199);
      if (p == 0) do_reset();
      else if (p < 110) cyc(1'b0, 1'b0, 1'b0, 4'h0);
      else if (p < 140) cyc(1'b1, 1'b0, 1'b0, 4'h0);
      else if (p < 170) cyc(1'b0, 1'b1, 1'b0, 4'h0);
      else if (p < 180) cyc(1'b1, 1'b1, 1'b0, 4'h0);
      else cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 4'($urandom));
    end

    idle(12);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d_pending_exits", d), 32'(exit_size(d)), 32'd0);
      chk($sformatf("dut%0d_pending_drops", d), 32'(drop_size(d)), 32'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
